burst_ram_arbiter: RTL and testbench
====================================

BURST_RAM_ARBITER -- requirements
Module: burst_ram_arbiter

Interface
REQ-001 SHALL have parameter CLIENT_COUNT, default 2, number of requesting clients (2..8).
REQ-002 SHALL have parameter DATA_BITWIDTH, default 64, burst beat width (multiple of 8).
REQ-003 SHALL have parameter ADDRESS_BITWIDTH, default 8, BurstRAM word address width.
REQ-004 SHALL have parameter BURST_COUNT, default 4, beats per read or write burst (2..16).
REQ-005 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-006 SHALL have ports: rst  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have ports: cl_req  in  CLIENT_COUNT  per-client request, held until granted.
REQ-008 SHALL have ports: cl_cmd  in  CLIENT_COUNT  per-client command, 0 read, 1 write.
REQ-009 SHALL have ports: cl_addr  in  CLIENT_COUNT*ADDRESS_BITWIDTH  packed per-client burst address.
REQ-010 SHALL have ports: cl_wr_data  in  CLIENT_COUNT*DATA_BITWIDTH  packed per-client write beat.
REQ-011 SHALL have ports: cl_data_mask  in  CLIENT_COUNT*DATA_BITWIDTH/8  packed per-client byte mask.
REQ-012 SHALL have ports: cl_grant  out  CLIENT_COUNT  one-hot grant, high for the whole transaction.
REQ-013 SHALL have ports: cl_rd_data  out  DATA_BITWIDTH  shared read beat.
REQ-014 SHALL have ports: cl_rd_data_valid  out  CLIENT_COUNT  per-client read beat valid.
REQ-015 SHALL have ports: br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask  out  BurstRAM command side, same widths as BurstRAM.
REQ-016 SHALL have ports: br_rd_data, br_rd_data_valid, br_busy  in  BurstRAM response side.

Function
REQ-017 SHALL implement states IDLE, CMD, WRITE, READ.
REQ-018 IDLE: if any cl_req high and br_busy low, SHALL register winner and enter CMD; else stay.
REQ-019 Winner SHALL be round-robin: first requesting client at or after (last_granted+1) mod CLIENT_COUNT; last_granted resets to CLIENT_COUNT-1 so client 0 wins first.
REQ-020 Request seen in IDLE at edge t SHALL give cl_grant high from t+1; no grant while br_busy high.
REQ-021 CMD (one cycle): br_cmd_en=1, br_cmd/br_addr/br_wr_data/br_data_mask muxed from granted client; next state WRITE if cmd=1 else READ.
REQ-022 WRITE: SHALL forward granted client's cl_wr_data/cl_data_mask for BURST_COUNT-1 further cycles (beat counter), br_cmd_en=0; after last beat return to IDLE.
REQ-023 READ: cl_rd_data SHALL equal br_rd_data; cl_rd_data_valid[g]=br_rd_data_valid, all other bits 0; after BURST_COUNT valid beats return to IDLE.
REQ-024 cl_grant SHALL drop the cycle after the last write beat or last read beat; at least one IDLE cycle between transactions.
REQ-025 Outside CMD/WRITE, br_cmd_en, br_cmd, br_addr, br_wr_data, br_data_mask SHALL be 0.
REQ-026 Client lowering cl_req after grant SHALL NOT abort; transaction completes to BURST_COUNT beats.
REQ-027 br_rd_data_valid outside READ SHALL be ignored and not counted.
REQ-028 Sole persistent requester SHALL be granted back-to-back, one IDLE cycle apart.
REQ-029 Beat counter SHALL be $clog2(BURST_COUNT)+1 bits, no wrap within a burst.

Reset
REQ-030 rst low SHALL immediately force state IDLE, beat counter 0, last_granted CLIENT_COUNT-1, and all outputs 0, including mid-burst.
REQ-031 After rst rises, first arbitration SHALL occur at the first rising edge with rst high.

Verification
REQ-032 CLIENT_COUNT=2: client 0 read addr 4 -> grant[0] next cycle, one br_cmd_en cycle with addr 4 cmd 0, 4 valid beats to client 0 only, valid[1] never high, grant drops after 4th beat.
REQ-033 Clients 0 and 1 request together from reset -> client 0 served, then client 1, then client 0 if both still request.
REQ-034 CLIENT_COUNT=4: client 2 write addr 8 beats 0x1111..., 0x2222..., 0x3333..., 0x4444..., mask 0xFF -> br_wr_data shows those 4 values on consecutive cycles starting at br_cmd_en, grant[2] only.
REQ-035 br_busy high while client 1 requests -> no grant; br_busy low at edge t -> grant[1] at t+1.
REQ-036 rst low during read beat 2 -> all outputs 0 at once; after release, client 0 and client 1 requesting -> client 0 granted first.
REQ-037 Client 0 drops cl_req after grant in a read -> all 4 beats still delivered to client 0, then IDLE.

Source files
------------

// File: rtl/burst_ram_arbiter_if.sv
// Client-side and BurstRAM-side signal bundle for burst_ram_arbiter.
// The master modport is the arbiter; slave is the environment (clients plus the BurstRAM).
interface burst_ram_arbiter_if #(
  parameter int unsigned CLIENT_COUNT     = 2,
  parameter int unsigned DATA_BITWIDTH    = 64,
  parameter int unsigned ADDRESS_BITWIDTH = 8
);
  localparam int unsigned MaskW = DATA_BITWIDTH / 8;

  logic [CLIENT_COUNT-1:0]                  cl_req;
  logic [CLIENT_COUNT-1:0]                  cl_cmd;
  logic [CLIENT_COUNT*ADDRESS_BITWIDTH-1:0] cl_addr;
  logic [CLIENT_COUNT*DATA_BITWIDTH-1:0]    cl_wr_data;
  logic [CLIENT_COUNT*MaskW-1:0]            cl_data_mask;
  logic [CLIENT_COUNT-1:0]                  cl_grant;
  logic [DATA_BITWIDTH-1:0]                 cl_rd_data;
  logic [CLIENT_COUNT-1:0]                  cl_rd_data_valid;

  logic                                     br_cmd;
  logic                                     br_cmd_en;
  logic [ADDRESS_BITWIDTH-1:0]              br_addr;
  logic [DATA_BITWIDTH-1:0]                 br_wr_data;
  logic [MaskW-1:0]                         br_data_mask;
  logic [DATA_BITWIDTH-1:0]                 br_rd_data;
  logic                                     br_rd_data_valid;
  logic                                     br_busy;

  modport master (
    input  cl_req, cl_cmd, cl_addr, cl_wr_data, cl_data_mask,
    output cl_grant, cl_rd_data, cl_rd_data_valid,
    output br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
    input  br_rd_data, br_rd_data_valid, br_busy
  );

  modport slave (
    output cl_req, cl_cmd, cl_addr, cl_wr_data, cl_data_mask,
    input  cl_grant, cl_rd_data, cl_rd_data_valid,
    input  br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask,
    output br_rd_data, br_rd_data_valid, br_busy
  );
endinterface

// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter granting one client at a time a full read or write burst on a BurstRAM.
// All outputs decode from registered state, so an asynchronous reset clears them at once.
module burst_ram_arbiter #(
  parameter int unsigned CLIENT_COUNT     = 2,
  parameter int unsigned DATA_BITWIDTH    = 64,
  parameter int unsigned ADDRESS_BITWIDTH = 8,
  parameter int unsigned BURST_COUNT      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  burst_ram_arbiter_if.master  bus
);
  localparam int unsigned IdxW  = $clog2(CLIENT_COUNT);
  localparam int unsigned BeatW = $clog2(BURST_COUNT) + 1;
  localparam int unsigned MaskW = DATA_BITWIDTH / 8;

  typedef enum logic [1:0] {StIdle, StCmd, StWrite, StRead} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  gnt_q, gnt_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic [BeatW-1:0] beat_q, beat_d;

  logic                        any_req;
  logic [IdxW-1:0]             winner;
  logic [IdxW-1:0]             cand;
  logic                        sel_cmd;
  logic [ADDRESS_BITWIDTH-1:0] sel_addr;
  logic [DATA_BITWIDTH-1:0]    sel_wr_data;
  logic [MaskW-1:0]            sel_mask;

  // Search starts one past the last winner and wraps, giving round-robin fairness.
  always_comb begin
    any_req = 1'b0;
    winner  = last_q;
    cand    = last_q;
    for (int unsigned i = 0; i < CLIENT_COUNT; i++) begin
      cand = (cand == IdxW'(CLIENT_COUNT - 1)) ? '0 : cand + 1'b1;
      if (!any_req && bus.cl_req[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  always_comb begin
    sel_cmd     = 1'b0;
    sel_addr    = '0;
    sel_wr_data = '0;
    sel_mask    = '0;
    for (int unsigned c = 0; c < CLIENT_COUNT; c++) begin
      if (gnt_q == IdxW'(c)) begin
        sel_cmd     = bus.cl_cmd[c];
        sel_addr    = bus.cl_addr[c*ADDRESS_BITWIDTH +: ADDRESS_BITWIDTH];
        sel_wr_data = bus.cl_wr_data[c*DATA_BITWIDTH +: DATA_BITWIDTH];
        sel_mask    = bus.cl_data_mask[c*MaskW +: MaskW];
      end
    end
  end

  always_comb begin
    state_d              = state_q;
    gnt_d                = gnt_q;
    last_d               = last_q;
    beat_d               = beat_q;
    bus.cl_grant         = '0;
    bus.cl_rd_data       = '0;
    bus.cl_rd_data_valid = '0;
    bus.br_cmd           = 1'b0;
    bus.br_cmd_en        = 1'b0;
    bus.br_addr          = '0;
    bus.br_wr_data       = '0;
    bus.br_data_mask     = '0;

    for (int unsigned c = 0; c < CLIENT_COUNT; c++) begin
      bus.cl_grant[c] = (state_q != StIdle) && (gnt_q == IdxW'(c));
    end

    unique case (state_q)
      StIdle: begin
        if (any_req && !bus.br_busy) begin
          state_d = StCmd;
          gnt_d   = winner;
          last_d  = winner;
          beat_d  = '0;
        end
      end
      StCmd: begin
        bus.br_cmd_en    = 1'b1;
        bus.br_cmd       = sel_cmd;
        bus.br_addr      = sel_addr;
        bus.br_wr_data   = sel_wr_data;
        bus.br_data_mask = sel_mask;
        // The command cycle carries write beat 0, so a write resumes counting at 1.
        beat_d           = sel_cmd ? BeatW'(1) : '0;
        state_d          = sel_cmd ? StWrite : StRead;
      end
      StWrite: begin
        bus.br_wr_data   = sel_wr_data;
        bus.br_data_mask = sel_mask;
        if (beat_q == BeatW'(BURST_COUNT - 1)) begin
          state_d = StIdle;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      StRead: begin
        bus.cl_rd_data = bus.br_rd_data;
        if (bus.br_rd_data_valid) begin
          bus.cl_rd_data_valid[gnt_q] = 1'b1;
          if (beat_q == BeatW'(BURST_COUNT - 1)) begin
            state_d = StIdle;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= IdxW'(CLIENT_COUNT - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end
endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Scoreboard bench for burst_ram_arbiter: directed scenarios plus randomized clients and BurstRAM,
// checked against a transaction-level round-robin model.
module tb_burst_ram_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int BC = 4;
  localparam int MW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  burst_ram_arbiter_if #(.CLIENT_COUNT(N), .DATA_BITWIDTH(DW), .ADDRESS_BITWIDTH(AW)) bus ();

  burst_ram_arbiter #(
    .CLIENT_COUNT(N), .DATA_BITWIDTH(DW), .ADDRESS_BITWIDTH(AW), .BURST_COUNT(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [7:0]              client;
    logic                    cmd;
    logic [AW-1:0]           addr;
    logic [BC-1:0][DW-1:0]   data;
    logic [BC-1:0][MW-1:0]   mask;
  } txn_t;

  int n_checks = 0;
  int n_pass   = 0;

  // Client agents
  bit                    c_req  [N];
  bit                    c_cmd  [N];
  bit                    c_drop [N];
  logic [AW-1:0]         c_addr [N];
  logic [BC-1:0][DW-1:0] c_data [N];
  logic [BC-1:0][MW-1:0] c_mask [N];
  int                    g_seen [N];
  bit                    busy_force = 1'b0;
  bit                    rand_mode  = 1'b0;

  // Reference model and scoreboard
  txn_t exp_q[$];
  txn_t cur;
  int   wr_idx;
  int   m_owner, m_last, m_left;
  bit   m_cmd_cycle, m_cmd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, bus.cl_grant, '0);
    chk({tag, "_rd_valid"}, bus.cl_rd_data_valid, '0);
    chk({tag, "_rd_data"}, bus.cl_rd_data, '0);
    chk({tag, "_br_side"},
        {bus.br_cmd_en, bus.br_cmd, bus.br_addr, bus.br_wr_data, bus.br_data_mask}, '0);
  endtask

  task automatic reset_model();
    m_owner = -1; m_last = N - 1; m_left = 0; m_cmd_cycle = 0; m_cmd = 0;
    exp_q.delete();
    wr_idx = BC;
    for (int c = 0; c < N; c++) g_seen[c] = 0;
  endtask

  task automatic new_request(input int c);
    c_req[c]  = 1'b1;
    c_cmd[c]  = ($urandom_range(1, 0) == 1);
    c_drop[c] = ($urandom_range(1, 0) == 1);
    c_addr[c] = AW'($urandom);
    for (int b = 0; b < BC; b++) begin
      c_data[c][b] = {$urandom, $urandom};
      c_mask[c][b] = MW'($urandom);
    end
  endtask

  // Runs just after each rising edge: advances client beats, then drives all inputs.
  task automatic drive_cycle();
    for (int c = 0; c < N; c++) begin
      int bi;
      bi = 0;
      if (bus.cl_grant[c]) begin
        bi = (g_seen[c] < BC) ? g_seen[c] : BC - 1;
        if (g_seen[c] == 0 && c_drop[c]) c_req[c] = 1'b0;
        g_seen[c]++;
      end else if (g_seen[c] > 0) begin
        g_seen[c] = 0;
        if (rand_mode) begin
          if ($urandom_range(1, 0) == 1) new_request(c);
          else c_req[c] = 1'b0;
        end
      end else if (rand_mode && !c_req[c] && $urandom_range(2, 0) == 0) begin
        new_request(c);
      end
      bus.cl_req[c]                 = c_req[c];
      bus.cl_cmd[c]                 = c_cmd[c];
      bus.cl_addr[c*AW +: AW]       = c_addr[c];
      bus.cl_wr_data[c*DW +: DW]    = c_data[c][bi];
      bus.cl_data_mask[c*MW +: MW]  = c_mask[c][bi];
    end
    bus.br_rd_data       = {$urandom, $urandom};
    bus.br_rd_data_valid = ($urandom_range(1, 0) == 1);
    bus.br_busy          = busy_force || (rand_mode && $urandom_range(3, 0) == 0);
  endtask

  // Transaction-level model: one owner at a time, a command cycle, then a burst of beats.
  task automatic model_step();
    logic [N-1:0] eg, ev;
    eg = '0;
    ev = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    if (m_owner >= 0 && !m_cmd_cycle && !m_cmd && bus.br_rd_data_valid) ev[m_owner] = 1'b1;
    chk("grant", bus.cl_grant, eg);
    chk("rd_valid", bus.cl_rd_data_valid, ev);
    chk("cmd_en", bus.br_cmd_en, m_cmd_cycle);
    if (m_owner < 0) begin
      if (bus.cl_req != '0 && !bus.br_busy) begin
        txn_t t;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (m_owner < 0 && bus.cl_req[c]) m_owner = c;
        end
        m_last      = m_owner;
        m_cmd       = c_cmd[m_owner];
        m_cmd_cycle = 1'b1;
        t.client    = 8'(m_owner);
        t.cmd       = c_cmd[m_owner];
        t.addr      = c_addr[m_owner];
        t.data      = c_data[m_owner];
        t.mask      = c_mask[m_owner];
        exp_q.push_back(t);
      end
    end else if (m_cmd_cycle) begin
      m_cmd_cycle = 1'b0;
      m_left      = m_cmd ? BC - 1 : BC;
    end else begin
      if (m_cmd || bus.br_rd_data_valid) m_left--;
      if (m_left == 0) m_owner = -1;
    end
  endtask

  task automatic monitor_step();
    if (bus.br_cmd_en) begin
      chk("sb_pending", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("cmd_grant", bus.cl_grant, 128'(1) << cur.client);
        chk("cmd_type", bus.br_cmd, cur.cmd);
        chk("cmd_addr", bus.br_addr, cur.addr);
        chk("wdata_beat0", bus.br_wr_data, cur.data[0]);
        chk("mask_beat0", bus.br_data_mask, cur.mask[0]);
        wr_idx = cur.cmd ? 1 : BC;
      end
    end else if (wr_idx < BC) begin
      chk("wdata_beat", bus.br_wr_data, cur.data[wr_idx]);
      chk("mask_beat", bus.br_data_mask, cur.mask[wr_idx]);
      chk("wr_grant", bus.cl_grant, 128'(1) << cur.client);
      wr_idx++;
    end else begin
      chk("br_quiet", {bus.br_cmd, bus.br_addr, bus.br_wr_data, bus.br_data_mask}, '0);
    end
    if (bus.cl_rd_data_valid != '0) chk("rd_data", bus.cl_rd_data, bus.br_rd_data);
    else if (bus.cl_grant == '0) chk("rd_data_idle", bus.cl_rd_data, '0);
  endtask

  task automatic next_grant(output logic [N-1:0] g);
    logic [N-1:0] prev;
    bit seen;
    prev = bus.cl_grant;
    seen = 1'b0;
    g    = '0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.cl_grant != '0 && prev == '0) begin
        g    = bus.cl_grant;
        seen = 1'b1;
      end
      prev = bus.cl_grant;
    end
    chk("grant_wait", seen, 1'b1);
  endtask

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 300 && quiet < 3; i++) begin
      @(negedge clk);
      if (bus.cl_grant == '0 && bus.cl_req == '0) quiet++;
      else quiet = 0;
    end
    chk("idle_wait", quiet >= 3, 1'b1);
  endtask

  initial forever begin
    @(posedge clk);
    #1 drive_cycle();
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      model_step();
      monitor_step();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] g;
    int beats;
    for (int c = 0; c < N; c++) begin
      c_req[c] = 0; c_cmd[c] = 0; c_drop[c] = 0; c_addr[c] = '0;
      c_data[c] = '0; c_mask[c] = '0;
    end
    bus.cl_req = '0; bus.cl_cmd = '0; bus.cl_addr = '0; bus.cl_wr_data = '0;
    bus.cl_data_mask = '0; bus.br_rd_data = '0; bus.br_rd_data_valid = 1'b0; bus.br_busy = 1'b0;
    reset_model();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 chk_zero("reset");
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Two persistent readers: 0, then 1, then 0 again.
    @(posedge clk);
    c_req[0] = 1; c_cmd[0] = 0; c_addr[0] = 8'd4;
    c_req[1] = 1; c_cmd[1] = 0; c_addr[1] = 8'd9;
    next_grant(g); chk("rr_first", g, 4'b0001);
    next_grant(g); chk("rr_second", g, 4'b0010);
    next_grant(g); chk("rr_third", g, 4'b0001);
    @(posedge clk);
    c_req[0] = 0; c_req[1] = 0;
    wait_idle();

    // Client 2 write burst with fixed patterns.
    @(posedge clk);
    c_req[2] = 1; c_cmd[2] = 1; c_addr[2] = 8'd8; c_drop[2] = 1;
    for (int b = 0; b < BC; b++) begin
      c_data[2][b] = {16{4'(b + 1)}};
      c_mask[2][b] = 8'hFF;
    end
    next_grant(g); chk("wr_grant2", g, 4'b0100);
    chk("wr_cmd_addr", bus.br_addr, 8'd8);
    for (int b = 0; b < BC; b++) begin
      logic [DW-1:0] pat;
      pat = {16{4'(b + 1)}};
      if (b > 0) @(negedge clk);
      chk("wr_pattern", bus.br_wr_data, pat);
    end
    wait_idle();

    // BurstRAM busy blocks arbitration.
    @(posedge clk);
    busy_force = 1; c_req[1] = 1; c_cmd[1] = 0; c_drop[1] = 1;
    repeat (6) begin
      @(negedge clk);
      chk("busy_hold", bus.cl_grant, '0);
    end
    @(posedge clk);
    busy_force = 0;
    @(negedge clk);
    chk("busy_release_same", bus.cl_grant, '0);
    @(negedge clk);
    chk("busy_release_next", bus.cl_grant, 4'b0010);
    wait_idle();

    // Client 0 drops its request right after the grant; the burst still completes.
    @(posedge clk);
    c_req[0] = 1; c_cmd[0] = 0; c_addr[0] = 8'd4; c_drop[0] = 1;
    next_grant(g); chk("drop_grant", g, 4'b0001);
    beats = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cl_grant == '0) break;
      if (bus.cl_rd_data_valid[0]) beats++;
    end
    chk("drop_beats", beats, 4);
    wait_idle();

    // Randomized traffic.
    rand_mode = 1;
    repeat (3000) @(posedge clk);
    rand_mode = 0;
    for (int c = 0; c < N; c++) c_req[c] = 0;
    wait_idle();

    // Reset in the middle of a read burst.
    @(posedge clk);
    c_req[0] = 1; c_cmd[0] = 0; c_drop[0] = 1;
    next_grant(g); chk("mid_grant", g, 4'b0001);
    beats = 0;
    for (int i = 0; i < 200 && beats < 2; i++) begin
      @(negedge clk);
      if (bus.cl_rd_data_valid[0]) beats++;
    end
    chk("mid_beats", beats, 2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("mid_reset");
    reset_model();
    c_req[0] = 1; c_cmd[0] = 0; c_drop[0] = 1;
    c_req[1] = 1; c_cmd[1] = 0; c_drop[1] = 1;
    @(posedge clk);
    #2 rst = 1'b1;
    next_grant(g); chk("post_reset_first", g, 4'b0001);
    @(posedge clk);
    c_req[0] = 0; c_req[1] = 0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
